// File: rtl/cpu_exec_responder.sv
// cpu_exec_responder: execution core behind the opcode/a/b -> result/done
// request interface. Accepts one request per valid/ready handshake, runs
// single-cycle ALU ops, a shift-add multiplier and, when CPU_EXEC_DIV_EN is
// defined, a restoring divider. Without CPU_EXEC_DIV_EN, opcodes 08/09 are
// treated as illegal.
module cpu_exec_responder #(
  parameter int WIDTH = 32,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  // The iterative states spend WIDTH step cycles plus one final cycle that
  // moves the finished value into result.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL = OPW'(7);
`ifdef CPU_EXEC_DIV_EN
  localparam logic [2:0]     S_DIV  = 3'd3;
  localparam logic [OPW-1:0] OP_DIV = OPW'(8);
  localparam logic [OPW-1:0] OP_REM = OPW'(9);
`endif

  logic [2:0]       state;
  logic [OPW-1:0]   opc;
  logic [WIDTH-1:0] op_a;   // MUL: shifting multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0] op_b;   // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc;    // MUL: partial product;       DIV: partial remainder
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_res;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Choose the execution path for an accepted opcode.
  function automatic logic [2:0] route(input logic [OPW-1:0] op);
    if (op <= OP_SHR)      return S_EXEC;
    else if (op == OP_MUL) return S_MUL;
`ifdef CPU_EXEC_DIV_EN
    else if (op == OP_DIV || op == OP_REM) return S_DIV;
`endif
    else                   return S_ERR;
  endfunction

  // Single-cycle ALU on the latched operands.
  always_comb begin
    // NOTE: default first so every path assigns alu_res and no latch is inferred.
    alu_res = '0;
    case (opc)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = op_a << op_b[SHW-1:0];
      OP_SHR:  alu_res = op_a >> op_b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef CPU_EXEC_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;
  always_comb begin
    rem_sh = {acc, op_a[WIDTH-1]};
    diff   = rem_sh - {1'b0, op_b};
    fits   = ~diff[WIDTH];
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so result/err read back as 0
      // after reset and no X reaches the outputs.
      state  <= S_IDLE;
      opc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            opc   <= opcode;
            op_a  <= a;
            op_b  <= b;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            state <= route(opcode);
          end
        end
        S_EXEC: begin
          result <= alu_res;
          state  <= S_DONE;
        end
        S_MUL: begin
          if (cnt == CNT_LAST) begin
            result <= acc;
            state  <= S_DONE;
          end else begin
            if (op_b[0]) acc <= acc + op_a;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
`ifdef CPU_EXEC_DIV_EN
        S_DIV: begin
          if (op_b == '0) begin
            // Divide by zero: skip iteration, report all-ones or the dividend.
            result <= (opc == OP_DIV) ? '1 : op_a;
            err    <= 1'b1;
            state  <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            result <= (opc == OP_DIV) ? op_a : acc;
            state  <= S_DONE;
          end else begin
            op_a <= {op_a[WIDTH-2:0], fits};
            acc  <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            cnt  <= cnt + CW'(1);
          end
        end
`endif
        S_ERR: begin
          result <= '0;
          err    <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_exec_responder.sv
// Self-checking bench for cpu_exec_responder (WIDTH=32, OPW=8): directed
// vector table, multi-cycle corner sequences, then randomized requests
// checked against a behavioural model. Honours CPU_EXEC_DIV_EN.
module tb_cpu_exec_responder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    opcode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  result;
  logic          done;
  logic          err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_prev = '0;

  cpu_exec_responder #(.WIDTH(W), .OPW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .a(a), .b(b), .result(result), .done(done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       e;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: result, err and accept-to-done latency.
  function automatic void model(input logic [7:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] r,
                                output logic e, output int lat);
    r = '0; e = 1'b0; lat = 2;
    case (op)
      8'd0: r = x + y;
      8'd1: r = x - y;
      8'd2: r = x & y;
      8'd3: r = x | y;
      8'd4: r = x ^ y;
      8'd5: r = x << (y % W);
      8'd6: r = x >> (y % W);
      8'd7: begin r = x * y; lat = W + 2; end
`ifdef CPU_EXEC_DIV_EN
      8'd8: if (y == 0) begin r = '1; e = 1'b1; end else begin r = x / y; lat = W + 2; end
      8'd9: if (y == 0) begin r = x;  e = 1'b1; end else begin r = x % y; lat = W + 2; end
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Issue one request starting at a negedge; returns on the negedge after done.
  task automatic run_req(input string name, input logic [7:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] r_o,
                         output logic e_o, output int lat_o);
    int guard = 0;
    opcode = op; a = x; b = y; req_valid = 1'b1;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check({name, " ready_timeout"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    opcode = 8'($urandom); a = $urandom; b = $urandom;
    check({name, " hold_result"}, 64'(result), 64'(exp_prev));
    check({name, " err_cleared"}, 64'(err), 64'd0);
    check({name, " busy"}, 64'({busy, req_ready}), 64'b10);
    lat_o = 1;
    while (!done && lat_o < W + 10) begin @(negedge clk); lat_o++; end
    r_o = result;
    e_o = err;
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] r, er;
    logic e, ee;
    int lat, elat, k;
    bit stall_ok, saw_done;

    rst_n = 1'b0; req_valid = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset state", 64'({req_ready, done, err, busy}), 64'b1000);
    check("reset result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{"add_wrap", 8'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 2});
    vecs.push_back('{"shl_mod", 8'd5, 32'd1, 32'd35, 32'd8, 1'b0, 2});
    vecs.push_back('{"shr_31", 8'd6, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 2});
    vecs.push_back('{"sub_wrap", 8'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2});
    vecs.push_back('{"and", 8'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 2});
    vecs.push_back('{"or", 8'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 2});
    vecs.push_back('{"xor", 8'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 2});
    vecs.push_back('{"mul", 8'd7, 32'd12345, 32'd6789, 32'd83810205, 1'b0, 34});
    vecs.push_back('{"mul_max", 8'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 34});
    vecs.push_back('{"illegal", 8'h7F, 32'd9, 32'd9, 32'd0, 1'b1, 2});
    vecs.push_back('{"add_after_err", 8'd0, 32'd1, 32'd1, 32'd2, 1'b0, 2});
`ifdef CPU_EXEC_DIV_EN
    vecs.push_back('{"div", 8'd8, 32'd100, 32'd7, 32'd14, 1'b0, 34});
    vecs.push_back('{"rem", 8'd9, 32'd100, 32'd7, 32'd2, 1'b0, 34});
    vecs.push_back('{"div_zero", 8'd8, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2});
    vecs.push_back('{"rem_zero", 8'd9, 32'd5, 32'd0, 32'd5, 1'b1, 2});
    vecs.push_back('{"div_big", 8'd8, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 34});
`else
    vecs.push_back('{"div_off", 8'd8, 32'd100, 32'd7, 32'd0, 1'b1, 2});
    vecs.push_back('{"rem_off", 8'd9, 32'd100, 32'd7, 32'd0, 1'b1, 2});
`endif

    foreach (vecs[i]) begin
      run_req(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat);
      check({vecs[i].name, " result"}, 64'(r), 64'(vecs[i].res));
      check({vecs[i].name, " err"}, 64'(e), 64'(vecs[i].e));
      check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
      exp_prev = vecs[i].res;
    end

    // Stall: valid held high through a MUL; the follow-up ADD waits for IDLE.
    opcode = 8'd7; a = 32'd12345; b = 32'd6789; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opcode = 8'd0; a = 32'd1; b = 32'd1;
    stall_ok = 1'b1;
    k = 1;
    while (!done && k < W + 10) begin
      if (req_ready) stall_ok = 1'b0;
      @(negedge clk); k++;
    end
    check("stall ready_low", 64'(stall_ok), 64'd1);
    check("stall mul latency", 64'(k), 64'd34);
    check("stall mul result", 64'(result), 64'd83810205);
    @(negedge clk);
    check("stall ready_after_done", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!done && k < W + 10) begin @(negedge clk); k++; end
    check("stall add latency", 64'(k), 64'd2);
    check("stall add result", 64'(result), 64'd2);
    @(negedge clk);

    // Reset in the middle of a MUL: no done, outputs back to reset values.
    opcode = 8'd7; a = 32'd3; b = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset result", 64'(result), 64'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midreset no_done", 64'(saw_done), 64'd0);
    check("midreset idle", 64'({req_ready, busy, err}), 64'b100);
    check("midreset result_after", 64'(result), 64'd0);
    exp_prev = '0;

    // Randomized requests against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] op;
      logic [W-1:0] x, y;
      int sel = $urandom_range(0, 11);
      if (sel <= 9) op = 8'(sel);
      else op = 8'($urandom_range(10, 255));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = 32'($urandom_range(1, 40));
        default: y = $urandom;
      endcase
      model(op, x, y, er, ee, elat);
      run_req("rand", op, x, y, r, e, lat);
      check($sformatf("rand op%0h a%0h b%0h result", op, x, y), 64'(r), 64'(er));
      check($sformatf("rand op%0h err", op), 64'(e), 64'(ee));
      check($sformatf("rand op%0h latency", op), 64'(lat), 64'(elat));
      exp_prev = er;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
